// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares a 1rw1r 32x256 SRAM between stream requesters and a
//            Wishbone host with bounded-wait arbitration per port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          MAX_WAIT  = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        s_wr_valid,
    input  logic [7:0]  s_wr_addr,
    input  logic [31:0] s_wr_data,
    output logic        s_wr_ready,
    input  logic        s_rd_valid,
    input  logic [7:0]  s_rd_addr,
    output logic        s_rd_ready,
    output logic        s_rd_rvalid,
    output logic [31:0] s_rd_rdata,
    output logic        R0_clk,
    output logic        W0_clk,
    output logic        R0_en,
    output logic [7:0]  R0_addr,
    input  logic [31:0] R0_data,
    output logic        W0_en,
    output logic [7:0]  W0_addr,
    output logic [31:0] W0_data
);

    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        RD_WAIT = 3'd2,
        RD_DATA = 3'd3,
        ACK     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_widx;
    logic [31:0] r_wdat;
    logic [31:0] r_dat_o;
    logic        r_rvalid;
    logic [3:0]  r_cnt_wr;
    logic [3:0]  r_cnt_rd;

    logic        w_req;
    logic [31:0] w_off;
    logic        w_in_win;
    logic        w_wr_wb_req;
    logic        w_wr_s_gnt;
    logic        w_wr_wb_gnt;
    logic        w_rd_wb_req;
    logic        w_rd_s_win;
    logic        w_rd_wb_win;
    logic [7:0]  w_rd_addr;
    logic        w_collide;
    logic        w_rd_s_gnt;
    logic        w_rd_wb_gnt;
    logic        w_unused_sel;

    assign w_unused_sel = &{1'b0, wbs_sel_i};

    assign w_req    = wbs_cyc_i & wbs_stb_i;
    assign w_off    = wbs_adr_i - BASE_ADDR;
    assign w_in_win = (w_off < 32'h0000_0400);

    // Write port: stream wins unless the Wishbone wait budget is exhausted.
    assign w_wr_wb_req = (r_state == WR_WAIT);
    assign w_wr_s_gnt  = s_wr_valid && (r_cnt_wr < C_MAX_WAIT);
    assign w_wr_wb_gnt = w_wr_wb_req && !w_wr_s_gnt;

    assign W0_en   = w_wr_s_gnt | w_wr_wb_gnt;
    assign W0_addr = w_wr_s_gnt ? s_wr_addr : (w_wr_wb_gnt ? r_widx : 8'h00);
    assign W0_data = w_wr_s_gnt ? s_wr_data : (w_wr_wb_gnt ? r_wdat : 32'h0);

    // Read port: a same-address write this cycle holds the read off one cycle.
    assign w_rd_wb_req = (r_state == RD_WAIT);
    assign w_rd_s_win  = s_rd_valid && (r_cnt_rd < C_MAX_WAIT);
    assign w_rd_wb_win = w_rd_wb_req && !w_rd_s_win;
    assign w_rd_addr   = w_rd_s_win ? s_rd_addr : r_widx;
    assign w_collide   = (w_rd_s_win | w_rd_wb_win) && W0_en && (w_rd_addr == W0_addr);
    assign w_rd_s_gnt  = w_rd_s_win && !w_collide;
    assign w_rd_wb_gnt = w_rd_wb_win && !w_collide;

    assign R0_en   = w_rd_s_gnt | w_rd_wb_gnt;
    assign R0_addr = R0_en ? w_rd_addr : 8'h00;

    assign s_wr_ready  = w_wr_s_gnt;
    assign s_rd_ready  = w_rd_s_gnt;
    assign s_rd_rvalid = r_rvalid;
    assign s_rd_rdata  = r_rvalid ? R0_data : 32'h0;

    assign R0_clk    = wb_clk_i;
    assign W0_clk    = wb_clk_i;
    assign wbs_ack_o = (r_state == ACK);
    assign wbs_dat_o = r_dat_o;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (!w_in_win)     w_state_nxt = ACK;
                    else if (wbs_we_i) w_state_nxt = WR_WAIT;
                    else               w_state_nxt = RD_WAIT;
                end
            end
            WR_WAIT: if (w_wr_wb_gnt) w_state_nxt = ACK;
            RD_WAIT: if (w_rd_wb_gnt) w_state_nxt = RD_DATA;
            RD_DATA: w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state  <= IDLE;
            r_widx   <= 8'h00;
            r_wdat   <= 32'h0;
            r_dat_o  <= 32'h0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= w_rd_s_gnt;
            if (r_state == IDLE && w_req) begin
                r_widx  <= wbs_adr_i[9:2];
                r_wdat  <= wbs_dat_i;
                r_dat_o <= 32'h0;
            end else if (r_state == RD_DATA) begin
                r_dat_o <= R0_data;
            end
        end
    end

    // Wait counters: collision stalls do not consume the read-side budget.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cnt_wr <= 4'd0;
            r_cnt_rd <= 4'd0;
        end else begin
            if (!w_wr_wb_req || w_wr_wb_gnt)
                r_cnt_wr <= 4'd0;
            else if (r_cnt_wr != C_MAX_WAIT)
                r_cnt_wr <= r_cnt_wr + 4'd1;

            if (!w_rd_wb_req || w_rd_wb_gnt)
                r_cnt_rd <= 4'd0;
            else if (!w_collide && r_cnt_rd != C_MAX_WAIT)
                r_cnt_rd <= r_cnt_rd + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Self-checking bench for sram_port_arbiter with an SRAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic        s_wr_valid;
    logic [7:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic        s_wr_ready;
    logic        s_rd_valid;
    logic [7:0]  s_rd_addr;
    logic        s_rd_ready;
    logic        s_rd_rvalid;
    logic [31:0] s_rd_rdata;
    logic        R0_clk, W0_clk;
    logic        R0_en;
    logic [7:0]  R0_addr;
    logic [31:0] R0_data;
    logic        W0_en;
    logic [7:0]  W0_addr;
    logic [31:0] W0_data;

    int total;
    int bad;
    int pops;
    logic [31:0] sbq[$];
    logic [31:0] shadow [256];
    logic [31:0] mem [256];

    sram_port_arbiter #(.BASE_ADDR(32'h3000_0000), .MAX_WAIT(4)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .s_wr_valid(s_wr_valid), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
        .s_wr_ready(s_wr_ready),
        .s_rd_valid(s_rd_valid), .s_rd_addr(s_rd_addr), .s_rd_ready(s_rd_ready),
        .s_rd_rvalid(s_rd_rvalid), .s_rd_rdata(s_rd_rdata),
        .R0_clk(R0_clk), .W0_clk(W0_clk),
        .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(R0_data),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (W0_en) mem[W0_addr] <= W0_data;
        if (R0_en) R0_data <= mem[R0_addr];
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp_rdat;
        int          exp_ack;
        int          exp_wen;
        int          exp_ren;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Sample point between edges; also runs the stream-read scoreboard.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (s_rd_rvalid) begin
            if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                e = sbq.pop_front();
                pops++;
                chk("sb_rdata", s_rd_rdata, e);
            end
        end
        if (s_rd_valid && s_rd_ready) sbq.push_back(shadow[s_rd_addr]);
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rdat, output int ack_c, output int wen_c,
                           output int ren_c, output logic [7:0] waddr,
                           output logic [31:0] wdata, output logic [7:0] raddr);
        drive();
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        ack_c = -1; wen_c = -1; ren_c = -1;
        rdat = 32'h0; waddr = 8'h0; wdata = 32'h0; raddr = 8'h0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (W0_en && wen_c < 0) begin wen_c = k; waddr = W0_addr; wdata = W0_data; end
            if (R0_en && ren_c < 0) begin ren_c = k; raddr = R0_addr; end
            if (ack) begin ack_c = k; rdat = dat_o; break; end
        end
        drive();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        logic [31:0] rdat, wdata, a;
        logic [7:0]  waddr, raddr;
        int ack_c, wen_c, ren_c;
        logic [7:0] rdy_m, wbw_m, ack_m;
        logic [7:0] wb_wa;
        logic [31:0] wb_wd;

        total = 0; bad = 0; pops = 0;
        rst_n = 1'b0;
        cyc = 0; stb = 0; we = 0; sel = 4'hF; adr = 0; dat_i = 0;
        s_wr_valid = 0; s_wr_addr = 0; s_wr_data = 0;
        s_rd_valid = 0; s_rd_addr = 0;

        vecs[0]  = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0,         2,  1, -1};
        vecs[1]  = '{1'b0, 32'h3000_0004, 32'h0,         32'hDEAD_BEEF, 3, -1,  1};
        vecs[2]  = '{1'b1, 32'h3000_03FC, 32'hA5A5_0001, 32'h0,         2,  1, -1};
        vecs[3]  = '{1'b0, 32'h3000_03FC, 32'h0,         32'hA5A5_0001, 3, -1,  1};
        vecs[4]  = '{1'b0, 32'h3000_0400, 32'h0,         32'h0,         1, -1, -1};
        vecs[5]  = '{1'b1, 32'h2FFF_FFFC, 32'h0000_0099, 32'h0,         1, -1, -1};
        vecs[6]  = '{1'b1, 32'h3000_0000, 32'h1111_1111, 32'h0,         2,  1, -1};
        vecs[7]  = '{1'b0, 32'h3000_0000, 32'h0,         32'h1111_1111, 3, -1,  1};
        vecs[8]  = '{1'b0, 32'h3000_03FC, 32'h0,         32'hA5A5_0001, 3, -1,  1};
        vecs[9]  = '{1'b1, 32'h3000_0010, 32'hCAFE_0010, 32'h0,         2,  1, -1};
        vecs[10] = '{1'b1, 32'h3000_0400, 32'h0000_0055, 32'h0,         1, -1, -1};

        // Reset state
        tick(); tick();
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_dat_o", dat_o, 32'h0);
        chk("rst_rvalid", {31'h0, s_rd_rvalid}, 32'h0);
        chk("rst_en", {30'h0, R0_en, W0_en}, 32'h0);
        chk("rst_ready", {30'h0, s_wr_ready, s_rd_ready}, 32'h0);
        chk("rst_addr", {16'h0, R0_addr, W0_addr}, 32'h0);
        chk("rst_wdata", W0_data, 32'h0);
        chk("rst_rdata", s_rd_rdata, 32'h0);
        rst_n = 1'b1;

        // Wishbone vector table
        for (int i = 0; i < 11; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, rdat, ack_c, wen_c, ren_c,
                    waddr, wdata, raddr);
            a = vecs[i].adr;
            chk($sformatf("v%0d_ack_cycle", i), ack_c, vecs[i].exp_ack);
            chk($sformatf("v%0d_w0en_cycle", i), wen_c, vecs[i].exp_wen);
            chk($sformatf("v%0d_r0en_cycle", i), ren_c, vecs[i].exp_ren);
            if (!vecs[i].we || vecs[i].exp_ack == 1)
                chk($sformatf("v%0d_dat_o", i), rdat, vecs[i].exp_rdat);
            if (vecs[i].exp_wen >= 0) begin
                chk($sformatf("v%0d_w0addr", i), {24'h0, waddr}, {24'h0, a[9:2]});
                chk($sformatf("v%0d_w0data", i), wdata, vecs[i].dat);
            end
            if (vecs[i].exp_ren >= 0)
                chk($sformatf("v%0d_r0addr", i), {24'h0, raddr}, {24'h0, a[9:2]});
        end

        // Reset asserted while the read is in RD_DATA
        drive();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010;
        tick();
        drive();
        tick();
        chk("midrst_r0en", {31'h0, R0_en}, 32'h1);
        drive();
        #2;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_outs", {28'h0, ack, R0_en, W0_en, s_rd_rvalid}, 32'h0);
            chk("midrst_dat_o", dat_o, 32'h0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("postrst_ack", {31'h0, ack}, 32'h0);
        end
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, rdat, ack_c, wen_c, ren_c, waddr, wdata, raddr);
        chk("postrst_rd_ack", ack_c, 32'd3);
        chk("postrst_rd_dat", rdat, 32'hCAFE_0010);

        // Bounded wait: stream write held high against a pending Wishbone write
        drive();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0008; dat_i = 32'h0000_0055;
        s_wr_valid = 1'b1; s_wr_addr = 8'h40; s_wr_data = 32'h0000_0077;
        shadow[8'h40] = 32'h0000_0077;
        rdy_m = 0; wbw_m = 0; ack_m = 0; wb_wa = 0; wb_wd = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            rdy_m[k] = s_wr_ready;
            ack_m[k] = ack;
            if (W0_en && !s_wr_ready) begin
                wbw_m[k] = 1'b1; wb_wa = W0_addr; wb_wd = W0_data;
            end
            drive();
            if (ack_m[k]) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
        end
        s_wr_valid = 1'b0;
        chk("maxwait_ready_mask", {24'h0, rdy_m}, 32'h0000_00DF);
        chk("maxwait_wbgrant_mask", {24'h0, wbw_m}, 32'h0000_0020);
        chk("maxwait_ack_mask", {24'h0, ack_m}, 32'h0000_0040);
        chk("maxwait_w0addr", {24'h0, wb_wa}, 32'h0000_0002);
        chk("maxwait_w0data", wb_wd, 32'h0000_0055);

        // Same-address stream write/read collision
        pops = 0;
        s_wr_valid = 1'b1; s_wr_addr = 8'h20; s_wr_data = 32'h0000_1234;
        shadow[8'h20] = 32'h0000_1234;
        s_rd_valid = 1'b1; s_rd_addr = 8'h20;
        tick();
        chk("coll_r0en_stall", {30'h0, R0_en, s_rd_ready}, 32'h0);
        chk("coll_wr_ready", {31'h0, s_wr_ready}, 32'h1);
        drive();
        s_wr_valid = 1'b0;
        tick();
        chk("coll_retry", {30'h0, R0_en, s_rd_ready}, 32'h3);
        drive();
        s_rd_valid = 1'b0;
        tick();
        chk("coll_rvalid", {31'h0, s_rd_rvalid}, 32'h1);
        chk("coll_pops", pops, 32'd1);

        // Back-to-back stream writes then reads, addresses 0..7
        for (int i = 0; i < 8; i++) begin
            drive();
            s_wr_valid = 1'b1; s_wr_addr = 8'(i); s_wr_data = 32'h100 + 32'(i) * 3;
            shadow[i] = 32'h100 + 32'(i) * 3;
            tick();
            chk($sformatf("b2b_wr_ready%0d", i), {31'h0, s_wr_ready}, 32'h1);
        end
        drive();
        s_wr_valid = 1'b0;
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            s_rd_valid = 1'b1; s_rd_addr = 8'(i);
            tick();
            chk($sformatf("b2b_rd_ready%0d", i), {31'h0, s_rd_ready}, 32'h1);
            if (i > 0) chk($sformatf("b2b_rvalid%0d", i), {31'h0, s_rd_rvalid}, 32'h1);
            drive();
        end
        s_rd_valid = 1'b0;
        tick();
        tick();
        chk("b2b_pops", pops, 32'd8);
        chk("sb_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the 1rw1r 32x256 spectrum SRAM between the streaming datapath and the Wishbone management host. Write port W0 is arbitrated between the stream writer and Wishbone writes; read port R0 between the stream reader and Wishbone reads. Stream requesters have priority, and a bounded-wait counter guarantees Wishbone progress. Same-cycle read/write collisions on one address are resolved by stalling the read. Sits between user_proj_example's datapath and the SRAM port wires in user_project_wrapper.

## Interface
- BASE_ADDR, 32'h3000_0000, Wishbone window base; window is BASE_ADDR..BASE_ADDR+0x3FF.
- MAX_WAIT, 4, max consecutive cycles (1..15) a pending Wishbone access loses to a stream requester on its port.

Ports:
- wb_clk_i  in  1  single clock; also driven out as R0_clk/W0_clk.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic controls.
- wbs_sel_i  in  4  ignored; full-word writes only (SRAM wmask fixed 4'b1111).
- wbs_adr_i  in  32  byte address; word index = adr[9:2].
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge, registered.
- wbs_dat_o  out  32  read data, registered, valid with ack.
- s_wr_valid  in  1, s_wr_addr  in  8, s_wr_data  in  32, s_wr_ready  out  1  stream write request.
- s_rd_valid  in  1, s_rd_addr  in  8, s_rd_ready  out  1  stream read request.
- s_rd_rvalid  out  1, s_rd_rdata  out  32  stream read return.
- R0_clk, W0_clk  out  1  = wb_clk_i.
- R0_en  out  1, R0_addr  out  8, R0_data  in  32  SRAM read port.
- W0_en  out  1, W0_addr  out  8, W0_data  out  32  SRAM write port.

## Operation
- Wishbone FSM states: IDLE, WR_WAIT, RD_WAIT, RD_DATA, ACK.
- IDLE: on cyc&stb sampled high, latch adr/dat/we. In-window write → WR_WAIT; in-window read → RD_WAIT; out-of-window → ACK with dat_o=0, no SRAM access.
- WR_WAIT: W0 request to arbiter; on grant (W0_en=1 for one cycle, latched addr/data) → ACK.
- RD_WAIT: R0 request; on grant (R0_en=1 for one cycle) → RD_DATA.
- RD_DATA: capture R0_data into wbs_dat_o → ACK.
- ACK: wbs_ack_o=1 for exactly one cycle → IDLE. An Wishbone request still asserted in IDLE is a new transaction.
- Per-port arbitration, evaluated combinationally each cycle: stream wins if its valid is high and that port's wait counter < MAX_WAIT; otherwise Wishbone wins.
- Wait counter (4 bit, one per port): increments each cycle Wishbone is waiting on that port and loses; clears when Wishbone is granted or not waiting; saturates at MAX_WAIT.
- s_wr_ready / s_rd_ready = stream grant on that port; a transfer occurs when valid&ready.
- Collision: when both ports are granted in the same cycle with R0_addr==W0_addr, the read grant is withheld (R0_en=0, s_rd_ready=0 or Wishbone stays in RD_WAIT). The read is retried next cycle and returns the newly written data. The read-side wait counter does not increment for a collision stall.
- s_rd_rvalid is registered: it is 1 in the cycle after a stream read handshake, with s_rd_rdata = R0_data passed through in that cycle.

## Timing
- Reset (async assert, sync release): FSM=IDLE; wbs_ack_o=0; wbs_dat_o=0; s_rd_rvalid=0; wait counters=0. Any in-flight transaction is dropped with no ack.
- With no stream reset-driven outputs, R0_en=W0_en=0, s_wr_ready=s_rd_ready=0, and all addr/data outputs are 0.
- Uncontended Wishbone write: stb in cycle 0; W0_en in cycle 1; ack in cycle 2.
- Uncontended Wishbone read: stb in cycle 0; R0_en in cycle 1; R0_data valid in cycle 2; ack+dat_o in cycle 3.
- Out-of-window access: ack in cycle 1.
- Contended access: each port delays Wishbone by at most MAX_WAIT cycles, plus 1 cycle per collision stall.
- Stream throughput: one write and one read per cycle when Wishbone is idle.

## Test plan
- Reset mid-read: assert wb_rst_ni=0 while in RD_DATA → ack never asserts, all outputs 0, and the next read of 0x3000_0010 completes normally.
- Wishbone write 0xDEADBEEF to 0x3000_0004, then read it back → W0_en cycle 1 with W0_addr=1, ack cycle 2; read ack cycle 3 with dat_o=0xDEADBEEF.
- s_wr_valid held high continuously while a Wishbone write is pending, MAX_WAIT=4 → s_wr_ready low in exactly cycle 5 of the wait, Wishbone W0_en in that cycle, and the stream resumes the next cycle.
- Stream write addr 0x20 data 0x1234 and stream read addr 0x20 in the same cycle → R0_en=0 that cycle; read granted next cycle; s_rd_rvalid one cycle later with rdata=0x1234.
- Read of 0x3000_0400 (out of window) → ack in cycle 1, dat_o=0, no R0_en or W0_en pulse.
- Back-to-back stream reads of addr 0..7 with Wishbone idle → s_rd_ready is 1 every cycle, and s_rd_rvalid appears one cycle after each read with data matching previously written values.
